// File: rtl/pipe_hazard_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the
// IF/ID / PC stall sequencer (slave).
interface pipe_hazard_if;
    logic [31:0] inst_i;
    logic        idex_memread;
    logic [4:0]  idex_rt;
    logic        mul_done_i;
    logic        pc_write;
    logic        ifid_write;
    logic        ifid_flush;
    logic        idex_flush;
    logic        busy;
    logic [1:0]  state_o;

    modport master (
        output inst_i, idex_memread, idex_rt, mul_done_i,
        input  pc_write, ifid_write, ifid_flush, idex_flush, busy, state_o
    );

    modport slave (
        input  inst_i, idex_memread, idex_rt, mul_done_i,
        output pc_write, ifid_write, ifid_flush, idex_flush, busy, state_o
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall sequencer for the 5-stage MIPS pipeline: inserts IF/ID NOP bubbles
// for branches, jumps and multi-cycle mul, and stalls on load-use hazards.
//
// state    | meaning
// IDLE     | normal issue; load-use stalls and sequence starts are decided here
// BR_WAIT  | issuing remaining beq/bne bubbles
// J_WAIT   | issuing remaining j bubbles
// MUL_WAIT | bubbling until mul_done_i or the mul timeout
module pipe_hazard_ctrl #(
    parameter int BR_BUBBLES = 2,
    parameter int J_BUBBLES  = 1,
    parameter int MUL_CYCLES = 34
) (
    input logic          clk,
    input logic          rst,
    pipe_hazard_if.slave hz
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BR_WAIT  = 2'd1,
        J_WAIT   = 2'd2,
        MUL_WAIT = 2'd3
    } state_t;

    localparam logic [5:0] BR_LAST  = 6'(BR_BUBBLES - 1);
    localparam logic [5:0] J_LAST   = 6'(J_BUBBLES - 1);
    localparam logic [5:0] MUL_LAST = 6'(MUL_CYCLES - 1);

    state_t     st;
    state_t     st_nxt;
    logic [5:0] cnt;
    logic [5:0] cnt_nxt;

    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [5:0] funct;
    logic       dec_br;
    logic       dec_jmp;
    logic       dec_mul;
    logic       dec_lu;
    logic       unused_bits;

    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_flush;

    assign op    = hz.inst_i[31:26];
    assign rs    = hz.inst_i[25:21];
    assign rt    = hz.inst_i[20:16];
    assign funct = hz.inst_i[5:0];
    // rd/shamt carry no hazard information
    assign unused_bits = ^hz.inst_i[15:6];

    assign dec_br  = (op == 6'd4) || (op == 6'd5);
    assign dec_jmp = (op == 6'd2);
    assign dec_mul = (op == 6'd0) && (funct == 6'd25);
    assign dec_lu  = hz.idex_memread && (hz.idex_rt != 5'd0) &&
                     ((hz.idex_rt == rs) || (hz.idex_rt == rt));

    always_ff @(posedge clk) begin
        if (rst) begin
            st  <= IDLE;
            cnt <= '0;
        end else begin
            st  <= st_nxt;
            cnt <= cnt_nxt;
        end
    end

    always_comb begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        st_nxt     = st;
        cnt_nxt    = cnt;
        if (!rst) begin
            case (st)
                IDLE: begin
                    if (dec_lu) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        idex_flush = 1'b1;
                    end else if (dec_mul) begin
                        ifid_flush = 1'b1;
                        if (MUL_CYCLES == 1) begin
                            pc_write = 1'b1;
                        end else begin
                            pc_write = 1'b0;
                            st_nxt   = MUL_WAIT;
                            cnt_nxt  = 6'd1;
                        end
                    end else if (dec_br) begin
                        ifid_flush = 1'b1;
                        if (BR_BUBBLES == 1) begin
                            pc_write = 1'b1;
                        end else begin
                            pc_write = 1'b0;
                            st_nxt   = BR_WAIT;
                            cnt_nxt  = 6'd1;
                        end
                    end else if (dec_jmp) begin
                        ifid_flush = 1'b1;
                        if (J_BUBBLES == 1) begin
                            pc_write = 1'b1;
                        end else begin
                            pc_write = 1'b0;
                            st_nxt   = J_WAIT;
                            cnt_nxt  = 6'd1;
                        end
                    end
                end
                BR_WAIT, J_WAIT: begin
                    ifid_flush = 1'b1;
                    if (cnt == ((st == BR_WAIT) ? BR_LAST : J_LAST)) begin
                        pc_write = 1'b1;
                        st_nxt   = IDLE;
                        cnt_nxt  = '0;
                    end else begin
                        pc_write = 1'b0;
                        cnt_nxt  = cnt + 6'd1;
                    end
                end
                MUL_WAIT: begin
                    ifid_flush = 1'b1;
                    // done pulse and timeout both force exit, so cnt never wraps
                    if (hz.mul_done_i || (cnt == MUL_LAST)) begin
                        pc_write = 1'b1;
                        st_nxt   = IDLE;
                        cnt_nxt  = '0;
                    end else begin
                        pc_write = 1'b0;
                        cnt_nxt  = cnt + 6'd1;
                    end
                end
                default: begin
                    st_nxt  = IDLE;
                    cnt_nxt = '0;
                end
            endcase
        end
    end

    assign hz.pc_write   = pc_write;
    assign hz.ifid_write = ifid_write;
    assign hz.ifid_flush = ifid_flush;
    assign hz.idex_flush = idex_flush;
    // st can still be non-IDLE in the first reset cycle; mask it
    assign hz.busy       = !rst && (st != IDLE);
    assign hz.state_o    = rst ? 2'd0 : st;
endmodule
